// File: rtl/cpc_uart_pkg.sv
// cpc_uart_pkg
// Shared definitions for the CPC I/O-port UART: register offsets within
// the 4-byte I/O window, STATUS bit positions, and the state encoding
// used by both the transmit and receive shift engines.
package cpc_uart_pkg;

  // Register offsets (cpu_addr[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVLO  = 2'd2;
  localparam logic [1:0] REG_DIVHI  = 2'd3;

  // STATUS register bit positions; bits 7:5 read as zero
  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  // Frame position, shared by the TX and RX engines
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/cpc_io_uart_if.sv
// cpc_io_uart_if
// Z80 I/O bus as seen on the CPC expansion port.
//   cpu_addr  : 16-bit I/O address            (master -> slave)
//   cpu_dout  : write data                    (master -> slave)
//   io_rd     : read strobe, level            (master -> slave)
//   io_wr     : write strobe, level           (master -> slave)
//   dout      : read data, 8'hFF when idle    (slave -> master)
// The motherboard ANDs all responders' dout together, so a responder
// that is not being read must return all ones.
interface cpc_io_uart_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  dout;

  modport master (output cpu_addr, output cpu_dout, output io_rd,
                  output io_wr, input dout);
  modport slave  (input cpu_addr, input cpu_dout, input io_rd,
                  input io_wr, output dout);
endinterface

// File: rtl/cpc_uart_fifo.sv
// cpc_uart_fifo
// Byte FIFO with registered pointers and occupancy count.
//   clk, rst    : clock, asynchronous active-high reset
//   push, push_data : write request and its byte
//   pop         : read request; head is the byte that pop removes
//   full, empty : occupancy flags (count == DEPTH / count == 0)
//   head        : oldest byte (undefined while empty)
// Handshake: push and pop are single-cycle requests. A push is taken only
// when !full and a pop only when !empty; a refused request has no effect.
// A taken push and a taken pop on the same clk leave the count unchanged.
module cpc_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cpc_io_uart.sv
// cpc_io_uart
// 8N1 UART responder on the CPC Z80 I/O bus, decoded at BASE_ADDR..+3.
//   clk, reset   : system clock, asynchronous active-high reset
//   ce           : 4 MHz clock enable; one baud tick per ce
//   bus          : I/O bus slave (cpu_addr, cpu_dout, io_rd, io_wr, dout)
//   txd          : serial out, idle high
//   rxd          : serial in, asynchronous to clk
//   rx_avail     : RX FIFO non-empty
//   dbg_tx_state : current TX engine state
//   dbg_rx_state : current RX engine state
// Registers: 0 DATA (rd RX head / wr push TX), 1 STATUS (ro),
// 2 DIV_LO, 3 DIV_HI. Bit period = DIV+1 ce ticks.
module cpc_io_uart
  import cpc_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'hFBD0,
  parameter logic [15:0] DIV_RESET  = 16'd416
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  cpc_io_uart_if.slave bus,
  output logic         txd,
  input  logic         rxd,
  output logic         rx_avail,
  output uart_state_t  dbg_tx_state,
  output uart_state_t  dbg_rx_state
);

  // ---------------- bus decode and strobe edges ----------------
  logic       sel;
  logic [1:0] reg_sel;
  logic       io_rd_q, io_wr_q, sel_q;
  logic [1:0] reg_q;
  logic       wr_fire, rd_done, stat_clr;

  assign sel     = (bus.cpu_addr[15:2] == BASE_ADDR[15:2]);
  assign reg_sel = bus.cpu_addr[1:0];
  // Writes act on the rising io_wr; read side effects on the falling io_rd,
  // using the address held on the last clk the strobe was high.
  assign wr_fire  = sel & bus.io_wr & ~io_wr_q;
  assign rd_done  = sel_q & io_rd_q & ~bus.io_rd;
  assign stat_clr = rd_done & (reg_q == REG_STATUS);

  // ---------------- registers and FIFOs ----------------
  logic [15:0] div_q, div_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        tx_push, tx_pop, tx_full, tx_fifo_empty;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        rx_byte_done, frame_err_set, overrun_set;

  assign tx_push     = wr_fire & (reg_sel == REG_DATA);
  assign rx_pop      = rd_done & (reg_q == REG_DATA);
  assign rx_push     = rx_byte_done & ~rx_full;
  assign overrun_set = rx_byte_done & rx_full;

  cpc_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset), .push(tx_push), .push_data(bus.cpu_dout),
    .pop(tx_pop), .full(tx_full), .empty(tx_fifo_empty), .head(tx_head)
  );

  cpc_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset), .push(rx_push), .push_data(rx_shift_q),
    .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // A flag set on the same clk as the clearing STATUS read survives
  always_comb begin
    div_d = div_q;
    if (wr_fire && reg_sel == REG_DIVLO) div_d[7:0]  = bus.cpu_dout;
    if (wr_fire && reg_sel == REG_DIVHI) div_d[15:8] = bus.cpu_dout;
    overrun_d   = (overrun_q & ~stat_clr) | overrun_set;
    frame_err_d = (frame_err_q & ~stat_clr) | frame_err_set;
  end

  // ---------------- TX engine ----------------
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  // tx_cnt counts down the ticks left in the current bit; it is reloaded
  // from div_q only at a bit boundary, so a new divisor never stretches
  // or shortens a bit already in progress.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = div_q;
          txd_d      = 1'b0;
          tx_state_d = START;
        end
      end
      START: if (ce) begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_q;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      DATA: if (ce) begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      STOP: if (ce) begin
        if (tx_cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data waits
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_cnt_d   = div_q;
            txd_d      = 1'b0;
            tx_state_d = START;
          end else begin
            txd_d      = 1'b1;
            tx_state_d = IDLE;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // ---------------- RX engine ----------------
  logic        rxd_s1_q, rxd_s2_q, rx_prev_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_brk_q, rx_brk_d;

  // rx_brk marks a failed stop bit: stay in STOP until the line is high
  // again so the low tail is not mistaken for a new start bit.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_brk_d      = rx_brk_q;
    rx_byte_done  = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_prev_q && !rxd_s2_q) begin
        // Sample point: the tick on which the count reaches zero, i.e.
        // (DIV>>1)+1 ticks after the edge, close to the middle of the bit
        rx_cnt_d   = {1'b0, div_q[15:1]};
        rx_state_d = START;
      end
      START: if (ce) begin
        if (rx_cnt_q == 16'd0) begin
          if (rxd_s2_q) rx_state_d = IDLE;
          else begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = DATA;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      DATA: if (ce) begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      STOP: begin
        if (rx_brk_q) begin
          if (rxd_s2_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (ce) begin
          if (rx_cnt_q == 16'd0) begin
            if (rxd_s2_q) begin
              rx_byte_done = 1'b1;
              rx_state_d   = IDLE;
            end else begin
              frame_err_set = 1'b1;
              rx_brk_d      = 1'b1;
            end
          end else rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
      sel_q       <= 1'b0;
      reg_q       <= 2'd0;
      div_q       <= DIV_RESET;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= IDLE;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      txd_q       <= 1'b1;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= IDLE;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_brk_q    <= 1'b0;
    end else begin
      io_rd_q     <= bus.io_rd;
      io_wr_q     <= bus.io_wr;
      sel_q       <= sel;
      reg_q       <= reg_sel;
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      rx_prev_q   <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_brk_q    <= rx_brk_d;
    end
  end

  // ---------------- read mux and outputs ----------------
  logic       tx_empty;
  logic [7:0] status, rd_val;

  assign tx_empty = tx_fifo_empty & (tx_state_q == IDLE);

  always_comb begin
    status               = 8'h00;
    status[ST_RX_AVAIL]  = ~rx_empty;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    case (reg_sel)
      REG_DATA:   rd_val = rx_empty ? 8'hFF : rx_head;
      REG_STATUS: rd_val = status;
      REG_DIVLO:  rd_val = div_q[7:0];
      default:    rd_val = div_q[15:8];
    endcase
  end

  assign bus.dout     = (sel & bus.io_rd) ? rd_val : 8'hFF;
  assign txd          = txd_q;
  assign rx_avail     = ~rx_empty;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_cpc_io_uart.sv
// tb_cpc_io_uart
// Directed bench for cpc_io_uart: register reset values, decode, TX frame
// timing, RX reception, FIFO overrun, framing error, false start and
// reset in the middle of a transmitted byte. ce pulses every 4th clk, so
// with DIV=3 one bit lasts 16 clk.
module tb_cpc_io_uart;
  import cpc_uart_pkg::*;

  logic        clk, reset, ce, rxd, txd, rx_avail;
  uart_state_t dbg_tx_state, dbg_rx_state;
  int          checks = 0;
  int          errors = 0;

  cpc_io_uart_if bus ();

  cpc_io_uart #(
    .FIFO_DEPTH(16), .BASE_ADDR(16'hFBD0), .DIV_RESET(16'd416)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus), .txd(txd), .rxd(rxd),
    .rx_avail(rx_avail), .dbg_tx_state(dbg_tx_state),
    .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- clock / ce / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        ce = (i == 3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker and driver tasks ----------------
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    bus.io_wr    = 1'b1;
    repeat (3) @(negedge clk);
    bus.io_wr = 1'b0;
    @(negedge clk);
  endtask

  // io_rd held for 3 clk; data taken while the strobe is still high
  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.io_rd    = 1'b1;
    repeat (3) @(negedge clk);
    d = bus.dout;
    bus.io_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_check(input logic [15:0] a, input logic [7:0] exp,
                          input string tag);
    logic [7:0] d;
    io_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  // One 8N1 frame at 16 clk per bit, followed by one idle bit time
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0] frame;
    logic       seen;
    int         n, k;

    reset        = 1'b1;
    rxd          = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {15'd0, txd}, 16'd1);
    check("rst_dout", {8'h00, bus.dout}, 16'h00FF);
    check("rst_rx_avail", {15'd0, rx_avail}, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset register values and address decode
    rd_check(16'hFBD1, 8'h04, "status_rst");
    rd_check(16'hFBD2, 8'hA0, "divlo_rst");
    rd_check(16'hFBD3, 8'h01, "divhi_rst");
    rd_check(16'hFBD4, 8'hFF, "unselected");
    rd_check(16'hFBD0, 8'hFF, "data_empty_rst");
    check("idle_txd", {15'd0, txd}, 16'd1);

    // Divisor 3 -> 4 ce ticks per bit
    io_write(16'hFBD2, 8'h03);
    io_write(16'hFBD3, 8'h00);
    rd_check(16'hFBD2, 8'h03, "divlo_wr");
    rd_check(16'hFBD3, 8'h00, "divhi_wr");

    // TX 8'h55: start 0, data LSB first, stop 1
    io_write(16'hFBD0, 8'h55);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (!txd) seen = 1'b1;
      else @(negedge clk);
    end
    check("tx_start_seen", {15'd0, seen}, 16'd1);
    frame = {1'b1, 8'h55, 1'b0};
    n = 0;
    k = 0;
    while (dbg_tx_state != IDLE && n < 400) begin
      if (k < 10 && n == 8 + 16 * k) begin
        check($sformatf("tx_bit%0d", k), {15'd0, txd}, {15'd0, frame[k]});
        k++;
      end
      @(negedge clk);
      n++;
    end
    check("tx_bits_sampled", 16'(k), 16'd10);
    // 40 ce ticks; the write task ends 2 clk after the start bit begins
    check("tx_frame_len", {15'd0, (n >= 155 && n <= 158)}, 16'd1);
    rd_check(16'hFBD1, 8'h04, "tx_empty_after");
    check("tx_idle_high", {15'd0, txd}, 16'd1);

    // RX two frames, read back in order, single pop per read
    send_rx(8'hA5, 1'b1);
    check("rx_avail_set", {15'd0, rx_avail}, 16'd1);
    send_rx(8'h3C, 1'b1);
    rd_check(16'hFBD0, 8'hA5, "rx_data0");
    rd_check(16'hFBD0, 8'h3C, "rx_data1");
    rd_check(16'hFBD0, 8'hFF, "rx_read_empty");
    check("rx_avail_clr", {15'd0, rx_avail}, 16'd0);

    // 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1);
    rd_check(16'hFBD1, 8'h0D, "status_overrun");
    rd_check(16'hFBD1, 8'h05, "status_ovr_cleared");
    for (int i = 0; i < 16; i++)
      rd_check(16'hFBD0, 8'(8'h10 + i), $sformatf("rx_fifo%0d", i));
    rd_check(16'hFBD0, 8'hFF, "rx_drained");

    // Stop bit low: frame error, no byte
    send_rx(8'h77, 1'b0);
    check("ferr_no_byte", {15'd0, rx_avail}, 16'd0);
    rd_check(16'hFBD1, 8'h14, "status_frame_err");
    rd_check(16'hFBD1, 8'h04, "frame_err_clr");

    // One-tick low glitch: false start
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_idle", {14'd0, dbg_rx_state}, {14'd0, IDLE});
    check("glitch_no_byte", {15'd0, rx_avail}, 16'd0);
    rd_check(16'hFBD1, 8'h04, "glitch_no_flag");
    send_rx(8'hC3, 1'b1);
    rd_check(16'hFBD0, 8'hC3, "rx_after_glitch");

    // Reset while data bit 0 of 8'hF0 (a 0) is on the line, second byte queued
    io_write(16'hFBD0, 8'hF0);
    io_write(16'hFBD0, 8'h0F);
    repeat (18) @(negedge clk);
    check("tx_mid_low", {15'd0, txd}, 16'd0);
    #2 reset = 1'b1;
    #1;
    check("rst_txd_async", {15'd0, txd}, 16'd1);
    check("rst_tx_idle", {14'd0, dbg_tx_state}, {14'd0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (!txd) n++;
    end
    check("tx_quiet_after_rst", 16'(n), 16'd0);
    rd_check(16'hFBD1, 8'h04, "status_after_rst");
    rd_check(16'hFBD2, 8'hA0, "divlo_after_rst");
    rd_check(16'hFBD3, 8'h01, "divhi_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
